scaler_v: RTL and testbench

- Vertical linear-interpolation down-scaler that sits directly downstream of scaler_h and consumes its do/de/hs/vs stream.
- It stores the previous input line and blends each pixel of the current line with the matching pixel of the stored line.
- It emits at most one output line per input line, so it supports scale factors from 1.0 (unity) upward (scale-down).

---
 rtl/scaler_pkg.sv | 8 +
 rtl/scaler_v_linebuf.sv | 19 +
 rtl/scaler_v.sv | 142 ++++++++++++++
 tb/tb_scaler_v.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// scaler_pkg: shared constants and helpers for the scaler blocks
package scaler_pkg;
   localparam int SCALER_V_LATENCY = 3;
   localparam int STEP_W = 16;
   function automatic int fb_of(input int pixel_step);
      return $clog2(pixel_step);
   endfunction
endpackage

// File: rtl/scaler_v_linebuf.sv
// scaler_v_linebuf: single-clock read-first line RAM with 1-cycle read latency
module scaler_v_linebuf #(
   parameter int DEPTH = 4096,
   parameter int W = 8,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wd,
   output logic [W-1:0]  rd
);
   logic [W-1:0] mem [DEPTH];
   // read returns the old content when the same address is written
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wd;
      rd <= mem[addr];
   end
endmodule

// File: rtl/scaler_v.sv
// scaler_v: vertical linear-interpolation down-scaler; SCALER_V_DBG_CNT_EN adds debug counters
module scaler_v
   import scaler_pkg::*;
#(
   parameter int PIXEL_STEP = 128,
   parameter int PIXEL_WIDTH = 8,
   parameter int COE_WIDTH = 8,
   parameter int LINE_SIZE_MAX = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [STEP_W-1:0]      scale_step,
   input  logic [PIXEL_WIDTH-1:0] di_i,
   input  logic                   de_i,
   input  logic                   hs_i,
   input  logic                   vs_i,
   output logic [PIXEL_WIDTH-1:0] do_o,
   output logic                   de_o,
   output logic                   hs_o,
`ifdef SCALER_V_DBG_CNT_EN
   output logic                   vs_o,
   output logic [15:0]            dbg_cntx_o,
   output logic [15:0]            dbg_cnty_o
`else
   output logic                   vs_o
`endif
);
   localparam int FB = fb_of(PIXEL_STEP);
   localparam int AW = $clog2(LINE_SIZE_MAX);
   localparam int XW = AW + 1;
   localparam int MW = PIXEL_WIDTH + COE_WIDTH;
   localparam int L = SCALER_V_LATENCY;

   logic                   synced, active, first;
   logic [15:0]            n, n_nxt;
   logic [31:0]            pos, pos_nxt;
   logic [STEP_W-1:0]      step;
   logic [XW-1:0]          x;
   logic [COE_WIDTH-1:0]   coe, s1_coe;
   logic                   frame_start, line_start, emit, pix;
   logic [PIXEL_WIDTH-1:0] prev, s1_cur;
   logic [MW-1:0]          s2_p0, s2_p1;
   logic [MW:0]            acc;
   logic [L-1:0]           de_sr, hs_sr, vs_sr;

   // line-start decode and next line position; an output line is emitted when
   // the integer part of pos points at the previous input line
   always_comb begin
      frame_start = hs_i & vs_i;
      line_start = hs_i & ~vs_i & synced;
      n_nxt = frame_start ? '0 : n + 16'd1;
      pos_nxt = frame_start ? '0 : active ? pos + 32'(step) : pos;
      emit = line_start && n_nxt != '0 && (pos_nxt >> FB) == 32'(n_nxt) - 32'd1;
      pix = de_i & ~hs_i & synced & (x < XW'(LINE_SIZE_MAX));
      acc = {1'b0, s2_p0} + {1'b0, s2_p1} + (MW+1)'(PIXEL_STEP / 2);
   end

   // frame/line bookkeeping: sync, line counter, position, coefficient, x
   always_ff @(posedge clk) begin
      if (rst) begin
         synced <= 1'b0;
         active <= 1'b0;
         first  <= 1'b0;
         n      <= '0;
         pos    <= '0;
         step   <= '0;
         x      <= '0;
         coe    <= '0;
      end else begin
         if (frame_start) begin
            synced <= 1'b1;
            step   <= scale_step < STEP_W'(PIXEL_STEP) ? STEP_W'(PIXEL_STEP) : scale_step;
         end
         if (frame_start) first <= 1'b1;
         else if (emit) first <= 1'b0;
         if (frame_start | line_start) begin
            n      <= n_nxt;
            pos    <= pos_nxt;
            x      <= '0;
            active <= emit;
            if (emit) coe <= COE_WIDTH'(pos_nxt[FB-1:0]);
         end else if (pix) x <= x + XW'(1);
      end
   end

   scaler_v_linebuf #(.DEPTH(LINE_SIZE_MAX), .W(PIXEL_WIDTH), .AW(AW)) u_linebuf (
      .clk (clk),
      .we  (pix),
      .addr(x[AW-1:0]),
      .wd  (di_i),
      .rd  (prev)
   );

   // control delay line aligned with the three datapath stages
   always_ff @(posedge clk) begin
      if (rst) begin
         de_sr <= '0;
         hs_sr <= '0;
         vs_sr <= '0;
      end else begin
         de_sr <= {de_sr[L-2:0], pix & active};
         hs_sr <= {hs_sr[L-2:0], emit};
         vs_sr <= {vs_sr[L-2:0], emit & first};
      end
   end

   // datapath: stage 1 captures current pixel, stage 2 multiplies, stage 3 rounds
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_cur <= '0;
         s1_coe <= '0;
         s2_p0  <= '0;
         s2_p1  <= '0;
         do_o   <= '0;
      end else begin
         s1_cur <= di_i;
         s1_coe <= coe;
         s2_p0  <= MW'(prev) * MW'(COE_WIDTH'(PIXEL_STEP) - s1_coe);
         s2_p1  <= MW'(s1_cur) * MW'(s1_coe);
         do_o   <= de_sr[L-2] ? PIXEL_WIDTH'(acc >> FB) : '0;
      end
   end

   assign de_o = de_sr[L-1];
   assign hs_o = hs_sr[L-1];
   assign vs_o = vs_sr[L-1];

`ifdef SCALER_V_DBG_CNT_EN
   // pixels per output line and lines per output frame
   always_ff @(posedge clk) begin
      if (rst) begin
         dbg_cntx_o <= '0;
         dbg_cnty_o <= '0;
      end else begin
         if (hs_o) dbg_cntx_o <= '0;
         else if (de_o) dbg_cntx_o <= dbg_cntx_o + 16'd1;
         if (hs_o & vs_o) dbg_cnty_o <= '0;
         else if (hs_o) dbg_cnty_o <= dbg_cnty_o + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_scaler_v.sv
// tb_scaler_v: scoreboard bench for the vertical down-scaler
module tb_scaler_v;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] scale_step = 16'd128;
   logic [7:0] di_i = '0;
   logic de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
   logic [7:0] do_o;
   logic de_o, hs_o, vs_o;

   typedef struct {
      bit  is_hs;
      bit  vs;
      int  d;
      time t;
   } exp_t;

   exp_t sb[$];
   exp_t me;
   int checks = 0;
   int failures = 0;
   int lines_seen = 0;
   int probe = -1;
   bit tb_synced = 1'b0;

   scaler_v dut (
      .clk       (clk),
      .rst       (rst),
      .scale_step(scale_step),
      .di_i      (di_i),
      .de_i      (de_i),
      .hs_i      (hs_i),
      .vs_i      (vs_i),
      .do_o      (do_o),
      .de_o      (de_o),
      .hs_o      (hs_o),
      .vs_o      (vs_o)
   );

   always #5 clk = ~clk;

   // monitor: pop one expectation per output event and compare value and timing
   always @(negedge clk) begin
      if (hs_o || de_o) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output hs=%0b vs=%0b de=%0b d=%0d at %0t, required none", hs_o, vs_o, de_o, do_o, $time);
         end else begin
            me = sb.pop_front();
            if (me.is_hs != hs_o || me.is_hs == de_o || me.vs != vs_o || (!me.is_hs && do_o != me.d[7:0]) || $time != me.t) begin
               failures++;
               $display("FAIL %s got hs=%0b vs=%0b de=%0b d=%0d t=%0t required vs=%0b d=%0d t=%0t",
                        me.is_hs ? "line_start" : "pixel", hs_o, vs_o, de_o, do_o, $time, me.vs, me.d, me.t);
            end
         end
         if (hs_o) lines_seen = vs_o ? 0 : lines_seen + 1;
         if (de_o && lines_seen == 1 && probe < 0) probe = int'(do_o);
      end
   end

   function automatic int pix(input int mode, input int y, input int x);
      return mode == 0 ? (16 * y + x) & 255 : (16 * y) & 255;
   endfunction

   task automatic drive(input logic h, input logic v, input logic d_e, input logic [7:0] d);
      @(negedge clk);
      hs_i = h;
      vs_i = v;
      de_i = d_e;
      di_i = d;
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({do_o, de_o, hs_o, vs_o} != 11'd0) begin
         failures++;
         $display("FAIL %s got do=%0d de=%0b hs=%0b vs=%0b required all zero", name, do_o, de_o, hs_o, vs_o);
      end
   endtask

   task automatic reset_mid();
      @(negedge clk);
      rst = 1'b1;
      hs_i = 1'b0;
      vs_i = 1'b0;
      de_i = 1'b0;
      @(posedge clk);
      sb.delete();
      tb_synced = 1'b0;
      @(negedge clk);
      check_zero("mid_reset_outputs");
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s_drain got %0d outputs missing required 0", name, sb.size());
      end
   endtask

   task automatic run_frame(input int step, input int lines, input int width, input int period,
                            input int mode, input bit with_vs, input int abort_y);
      int s, k, coe;
      bit emit, aborted;
      s = step < 128 ? 128 : step;
      scale_step = 16'(step);
      for (int y = 0; y < lines; y++) begin
         if (y == 0 && with_vs) tb_synced = 1'b1;
         emit = 1'b0;
         coe = 0;
         if (tb_synced && y >= 1) begin
            k = ((y - 1) * 128 + s - 1) / s;
            if ((k * s) / 128 == y - 1) begin
               emit = 1'b1;
               coe = (k * s) % 128;
            end
         end
         drive(1'b1, y == 0 && with_vs, 1'b0, 8'd0);
         if (emit) sb.push_back('{1'b1, y == 1, 0, $time + 30});
         drive(1'b0, 1'b0, 1'b0, 8'd0);
         drive(1'b0, 1'b0, 1'b0, 8'd0);
         aborted = 1'b0;
         for (int x = 0; x < width && !aborted; x++) begin
            if (y == abort_y && x == 5) begin
               reset_mid();
               aborted = 1'b1;
            end else begin
               drive(1'b0, 1'b0, 1'b1, 8'(pix(mode, y, x)));
               if (emit && x < 4096)
                  sb.push_back('{1'b0, 1'b0,
                                 (pix(mode, y - 1, x) * (128 - coe) + pix(mode, y, x) * coe + 64) >> 7,
                                 $time + 30});
               repeat (period - 1) drive(1'b0, 1'b0, 1'b0, 8'd0);
            end
         end
         drive(1'b0, 1'b0, 1'b0, 8'd0);
         drive(1'b0, 1'b0, 1'b0, 8'd0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_zero("reset_outputs");
      rst = 1'b0;
      run_frame(128, 3, 16, 1, 0, 1'b0, -1);
      drain("unsynced");
      run_frame(128, 34, 16, 1, 0, 1'b1, -1);
      drain("unity");
      run_frame(256, 34, 16, 1, 0, 1'b1, -1);
      drain("step256");
      probe = -1;
      run_frame(170, 10, 16, 1, 1, 1'b1, -1);
      drain("step170");
      checks++;
      if (probe != 21) begin
         failures++;
         $display("FAIL step170_line1 got %0d required 21", probe);
      end
      run_frame(128, 34, 16, 4, 0, 1'b1, -1);
      drain("gaps");
      run_frame(128, 34, 16, 1, 0, 1'b1, 10);
      drain("aborted");
      run_frame(128, 34, 16, 1, 0, 1'b1, -1);
      drain("after_reset");
      run_frame(100, 3, 4100, 1, 0, 1'b1, -1);
      drain("step100_wide");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
